adder_1: RTL and testbench

- Half adder with WIDTH-bit operands. Combinational sum and carry-out, plus a registered copy of the result and a valid flag.
- Default WIDTH=1 gives the classic 1-bit half adder: s = a XOR b, c = a AND b.
- Used as a leaf arithmetic cell. Combinational outputs feed same-cycle logic; registered outputs feed pipelined consumers.

---
 rtl/adder_1.sv | 67 ++++++
 tb/tb_adder_1.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adder_1.sv
// Half adder with WIDTH-bit operands: combinational {c,s} = a + b plus a registered copy.
// Optional carry-event counter enabled by defining ADDER_1_CARRY_CNT_EN.
module adder_1 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic [WIDTH-1:0] s_q,
    output logic             c_q,
    output logic             vld_q,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] carry_cnt
);

    logic [WIDTH:0] sum_full;

    // Zero-extend to WIDTH+1 so the carry lands in the top bit.
    always_comb begin
        sum_full = {1'b0, a} + {1'b0, b};
    end

    assign s = sum_full[WIDTH-1:0];
    assign c = sum_full[WIDTH];

    // vld_q pulses for exactly one cycle per capture; s_q/c_q hold while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            c_q   <= 1'b0;
            vld_q <= 1'b0;
        end else if (en) begin
            s_q   <= s;
            c_q   <= c;
            vld_q <= 1'b1;
        end else begin
            vld_q <= 1'b0;
        end
    end

`ifdef ADDER_1_CARRY_CNT_EN
    logic [CNT_W-1:0] carry_cnt_q;

    // Saturating count of captured carries; clear takes priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt_q <= '0;
        end else if (cnt_clr) begin
            carry_cnt_q <= '0;
        end else if (en && c && (carry_cnt_q != {CNT_W{1'b1}})) begin
            carry_cnt_q <= carry_cnt_q + CNT_W'(1);
        end
    end

    assign carry_cnt = carry_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign carry_cnt      = '0;
`endif

endmodule

// File: tb/tb_adder_1.sv
// Directed self-checking bench for adder_1: WIDTH=1 (CNT_W=2) and WIDTH=4 instances.
module tb_adder_1;

    logic       clk;
    logic       rst;
    logic       a1, b1, en1, cnt_clr1;
    logic       s1, c1, s_q1, c_q1, vld_q1;
    logic [1:0] carry_cnt1;

    logic [3:0] a4, b4, s4, s_q4;
    logic       en4, cnt_clr4, c4, c_q4, vld_q4;
    logic [7:0] carry_cnt4;

    int total;
    int bad;

    adder_1 #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .en(en1),
        .s(s1), .c(c1), .s_q(s_q1), .c_q(c_q1), .vld_q(vld_q1),
        .cnt_clr(cnt_clr1), .carry_cnt(carry_cnt1)
    );

    adder_1 #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .en(en4),
        .s(s4), .c(c4), .s_q(s_q4), .c_q(c_q4), .vld_q(vld_q4),
        .cnt_clr(cnt_clr4), .carry_cnt(carry_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cnt_clr1 = 1'b0;
        cycle();
        cycle();
        total++;
        if ({s_q1, c_q1, vld_q1} !== 3'b000) begin
            bad++;
            $display("FAIL reset_regs got=%b required=000", {s_q1, c_q1, vld_q1});
        end
        total++;
        if (carry_cnt1 !== 2'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d required=0", carry_cnt1);
        end
    endtask

    task automatic test_comb_w1();
        logic [1:0] exp_sc [4];
        exp_sc[0] = 2'b00; exp_sc[1] = 2'b10; exp_sc[2] = 2'b10; exp_sc[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #10;
            total++;
            if ({s1, c1} !== exp_sc[i]) begin
                bad++;
                $display("FAIL comb_w1 a=%b b=%b got s,c=%b required=%b", a1, b1, {s1, c1},
                         exp_sc[i]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        rst = 1'b0; a1 = 1'b1; b1 = 1'b1; en1 = 1'b1;
        cycle();
        total++;
        if ({s_q1, c_q1, vld_q1} !== 3'b011) begin
            bad++;
            $display("FAIL latency_capture got=%b required=011", {s_q1, c_q1, vld_q1});
        end
        @(negedge clk);
        en1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        cycle();
        total++;
        if ({s_q1, c_q1, vld_q1} !== 3'b010) begin
            bad++;
            $display("FAIL latency_hold got=%b required=010", {s_q1, c_q1, vld_q1});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; en1 = 1'b1;
        cycle();
        total++;
        if ({s_q1, c_q1, vld_q1} !== 3'b101) begin
            bad++;
            $display("FAIL mid_pre got=%b required=101", {s_q1, c_q1, vld_q1});
        end
        @(negedge clk);
        rst = 1'b1;
        cycle();
        total++;
        if ({s_q1, c_q1, vld_q1} !== 3'b000) begin
            bad++;
            $display("FAIL mid_rst_regs got=%b required=000", {s_q1, c_q1, vld_q1});
        end
        total++;
        if ({s1, c1} !== 2'b10) begin
            bad++;
            $display("FAIL mid_rst_comb got=%b required=10", {s1, c1});
        end
        @(negedge clk);
        rst = 1'b0;
        cycle();
        total++;
        if ({s_q1, c_q1, vld_q1} !== 3'b101) begin
            bad++;
            $display("FAIL mid_resume got=%b required=101", {s_q1, c_q1, vld_q1});
        end
    endtask

    task automatic test_w4();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic [4:0] exp_cs [4];
        va[0] = 4'hF; vb[0] = 4'h1; exp_cs[0] = 5'h10;
        va[1] = 4'h7; vb[1] = 4'h8; exp_cs[1] = 5'h0F;
        va[2] = 4'h5; vb[2] = 4'h3; exp_cs[2] = 5'h08;
        va[3] = 4'hF; vb[3] = 4'hF; exp_cs[3] = 5'h1E;
        for (int i = 0; i < 4; i++) begin
            a4 = va[i];
            b4 = vb[i];
            #1;
            total++;
            if ({c4, s4} !== exp_cs[i]) begin
                bad++;
                $display("FAIL w4_sum a=%h b=%h got c,s=%h required=%h", a4, b4, {c4, s4},
                         exp_cs[i]);
            end
        end
    endtask

    task automatic test_back_to_back_cnt();
        logic [1:0] exp_cnt [4];
`ifdef ADDER_1_CARRY_CNT_EN
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
`else
        exp_cnt[0] = 2'd0; exp_cnt[1] = 2'd0; exp_cnt[2] = 2'd0; exp_cnt[3] = 2'd0;
`endif
        @(negedge clk);
        en1 = 1'b0; cnt_clr1 = 1'b1;
        cycle();
        total++;
        if (carry_cnt1 !== 2'd0) begin
            bad++;
            $display("FAIL cnt_preclear got=%0d required=0", carry_cnt1);
        end
        @(negedge clk);
        cnt_clr1 = 1'b0; a1 = 1'b1; b1 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++;
            if (carry_cnt1 !== exp_cnt[i]) begin
                bad++;
                $display("FAIL cnt_step%0d got=%0d required=%0d", i, carry_cnt1, exp_cnt[i]);
            end
            total++;
            if ({s_q1, c_q1, vld_q1} !== 3'b011) begin
                bad++;
                $display("FAIL b2b_step%0d got=%b required=011", i, {s_q1, c_q1, vld_q1});
            end
        end
        @(negedge clk);
        cnt_clr1 = 1'b1;
        cycle();
        total++;
        if (carry_cnt1 !== 2'd0) begin
            bad++;
            $display("FAIL cnt_clear got=%0d required=0", carry_cnt1);
        end
        @(negedge clk);
        cnt_clr1 = 1'b0; en1 = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; a1 = 1'b0; b1 = 1'b0; en1 = 1'b0; cnt_clr1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; en4 = 1'b0; cnt_clr4 = 1'b0;
        test_comb_w1();
        test_reset();
        test_latency();
        test_reset_mid();
        test_w4();
        test_back_to_back_cnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
